// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte/word/block transforms used by every round stage.
// Block and key layout: bits [127:120] hold byte 0, bytes run column-major.
package aes_pkg;

    localparam int NR = 10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes a0..a3 sit MSB-first; 02/03/01/01 circulant matrix.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte s[row][c] lives at index row + 4*c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_round.sv
// One AES encryption round: combinational round function and on-the-fly key
// expansion, with the resulting state and round key registered together.
module aes_round
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] prev_state,
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    input  logic         last_round,
    output logic [127:0] next_state,
    output logic [127:0] next_key
);

    logic [31:0]  w0, w1, w2, w3, temp;
    logic [127:0] key_c;
    logic [127:0] sub_c;
    logic [127:0] sr_c;
    logic [127:0] mix_c;
    logic [127:0] state_c;

    always_comb begin
        w0    = prev_key[127:96];
        w1    = prev_key[95:64];
        w2    = prev_key[63:32];
        w3    = prev_key[31:0];
        temp  = sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
        key_c = '0;
        key_c[127:96] = w0 ^ temp;
        key_c[95:64]  = w1 ^ key_c[127:96];
        key_c[63:32]  = w2 ^ key_c[95:64];
        key_c[31:0]   = w3 ^ key_c[63:32];
    end

    always_comb begin
        sub_c = '0;
        for (int i = 0; i < 16; i++) begin
            sub_c[8*i +: 8] = sbox(prev_state[8*i +: 8]);
        end
        sr_c = shift_rows(sub_c);
        mix_c = '0;
        for (int c = 0; c < 4; c++) begin
            mix_c[32*c +: 32] = mix_column(sr_c[32*c +: 32]);
        end
        // The final round skips MixColumns.
        state_c = (last_round ? sr_c : mix_c) ^ key_c;
    end

    // Round output register: state and its round key advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_state <= '0;
            next_key   <= '0;
        end else begin
            next_state <= state_c;
            next_key   <= key_c;
        end
    end

endmodule

// File: rtl/aes_128_pipe.sv
// Fully unrolled AES-128 encryption pipeline: one block in and one block out
// per clock, ciphertext valid 10 clocks after the capturing edge.
module aes_128_pipe
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
);

    logic [127:0] state_p0;
    logic [127:0] key_p0;
    logic [127:0] pipe_state [0:NR];
    logic [127:0] pipe_key   [0:NR];

    // Stage 0: initial AddRoundKey with the cipher key itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= '0;
            key_p0   <= '0;
        end else begin
            state_p0 <= state ^ key;
            key_p0   <= key;
        end
    end

    assign pipe_state[0] = state_p0;
    assign pipe_key[0]   = key_p0;

    // Stages 1..NR: one registered round each.
    for (genvar r = 1; r <= NR; r++) begin : g_round
        aes_round u_round (
            .clk        (clk),
            .rst        (rst),
            .prev_state (pipe_state[r-1]),
            .prev_key   (pipe_key[r-1]),
            .rcon       (RCON[r]),
            .last_round (r == NR),
            .next_state (pipe_state[r]),
            .next_key   (pipe_key[r])
        );
    end

    assign out = pipe_state[NR];

endmodule

// File: tb/tb_aes_128_pipe.sv
// Scoreboard bench for aes_128_pipe: stimulus queues expected ciphertexts with
// their due cycle, an independent monitor compares whenever an entry falls due.
`timescale 1ns/1ps
module tb_aes_128_pipe;

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    typedef struct {
        int           due;
        logic [127:0] val;
        string        name;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [127:0] state;
    logic [127:0] key;
    logic [127:0] out;

    int   cyc;
    int   tests;
    int   fails;
    bit   forbid_b;
    exp_t q [$];

    aes_128_pipe dut (
        .clk   (clk),
        .rst   (rst),
        .state (state),
        .key   (key),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a falling edge; the block is captured on the next rising edge.
    task automatic issue(input logic [127:0] pt, input logic [127:0] k,
                         input logic [127:0] ct, input string name);
        exp_t e;
        state = pt;
        key   = k;
        e.due  = cyc + 11;
        e.val  = ct;
        e.name = name;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        state = '0;
        key   = '0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s_missed: due cycle %0d, now %0d", q[0].name, q[0].due, cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                check(q[0].name, out, q[0].val);
                void'(q.pop_front());
            end
            if (forbid_b) begin
                tests++;
                if (out === B_CT) begin
                    fails++;
                    $display("FAIL stale_b: got %h required anything but %h", out, B_CT);
                end
            end
        end
    end

    initial begin
        tests    = 0;
        fails    = 0;
        forbid_b = 1'b0;
        rst      = 1'b1;
        state    = '0;
        key      = '0;
        #3;
        check("reset_out", out, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(12);

        issue(B_PT, B_KEY, B_CT, "fips_b");
        idle(12);
        issue(C_PT, C_KEY, C_CT, "fips_c1");
        idle(12);
        issue('0, '0, Z_CT, "all_zero");
        idle(12);

        issue(B_PT, B_KEY, B_CT, "tput_b");
        issue(C_PT, C_KEY, C_CT, "tput_c1");
        issue('0, '0, Z_CT, "tput_zero");
        idle(12);

        // Reset lands mid-flight: the B block must be discarded.
        issue(B_PT, B_KEY, B_CT, "flushed_b");
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check("rst_async_out", out, '0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        forbid_b = 1'b1;
        issue(C_PT, C_KEY, C_CT, "post_rst_c1");
        idle(15);
        forbid_b = 1'b0;

        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected outputs never checked, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
